// File: rtl/gray_code_unit.sv
// Gray-code converter and Gray up/down counter with registered outputs.
// Down counting is built only when the GRAY_DOWN_EN macro is defined.
module gray_code_unit #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] din,
    input  logic             cnt_en,
    input  logic             cnt_load,
    input  logic             cnt_dn,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    output logic             wrap
);

    typedef enum logic [1:0] {
        ModeBin2Gray = 2'b00,
        ModeGray2Bin = 2'b01,
        ModeCount    = 2'b10,
        ModeHold     = 2'b11
    } mode_e;

    function automatic logic [WIDTH-1:0] f_bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the running XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] f_gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    mode_e            w_mode;
    logic             w_step_dn;
    logic [WIDTH-1:0] w_cnt_d;
    logic [WIDTH-1:0] w_dout_d;
    logic             w_out_valid_d;
    logic             w_wrap_d;

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_out_valid;
    logic             r_wrap;

    assign w_mode = mode_e'(mode);

`ifdef GRAY_DOWN_EN
    assign w_step_dn = cnt_dn;
`else
    logic w_unused_cnt_dn;
    assign w_unused_cnt_dn = cnt_dn;
    assign w_step_dn       = 1'b0;
`endif

    always_comb begin
        w_cnt_d       = r_cnt;
        w_dout_d      = r_dout;
        w_out_valid_d = 1'b0;
        w_wrap_d      = 1'b0;
        unique case (w_mode)
            ModeBin2Gray: begin
                if (in_valid) begin
                    w_dout_d      = f_bin2gray(din);
                    w_out_valid_d = 1'b1;
                end
            end
            ModeGray2Bin: begin
                if (in_valid) begin
                    w_dout_d      = f_gray2bin(din);
                    w_out_valid_d = 1'b1;
                end
            end
            ModeCount: begin
                if (cnt_load) begin
                    w_cnt_d       = din;
                    w_dout_d      = f_bin2gray(din);
                    w_out_valid_d = 1'b1;
                end else if (cnt_en) begin
                    if (w_step_dn) begin
                        w_cnt_d  = r_cnt - WIDTH'(1);
                        w_wrap_d = (r_cnt == '0);
                    end else begin
                        w_cnt_d  = r_cnt + WIDTH'(1);
                        w_wrap_d = (r_cnt == '1);
                    end
                    w_dout_d      = f_bin2gray(w_cnt_d);
                    w_out_valid_d = 1'b1;
                end
            end
            ModeHold: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_d;
            r_dout      <= w_dout_d;
            r_out_valid <= w_out_valid_d;
            r_wrap      <= w_wrap_d;
        end
    end

    assign dout      = r_dout;
    assign out_valid = r_out_valid;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_gray_code_unit.sv
// Self-checking bench for gray_code_unit (WIDTH=3): directed cases plus
// randomized traffic against an arithmetic reference model.
module tb_gray_code_unit;

    localparam int unsigned WIDTH = 3;
    localparam int MOD = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic             in_valid;
    logic [WIDTH-1:0] din;
    logic             cnt_en;
    logic             cnt_load;
    logic             cnt_dn;
    logic [WIDTH-1:0] dout;
    logic             out_valid;
    logic             wrap;

    int checks   = 0;
    int failures = 0;

    int m_cnt  = 0;
    int m_dout = 0;
    int m_ov   = 0;
    int m_wrap = 0;

`ifdef GRAY_DOWN_EN
    localparam bit DownEn = 1'b1;
`else
    localparam bit DownEn = 1'b0;
`endif

    gray_code_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .in_valid (in_valid),
        .din      (din),
        .cnt_en   (cnt_en),
        .cnt_load (cnt_load),
        .cnt_dn   (cnt_dn),
        .dout     (dout),
        .out_valid(out_valid),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    function automatic int gray_of(input int x);
        return x ^ (x >> 1);
    endfunction

    function automatic int bin_of(input int g);
        int b = g;
        for (int s = 1; s < int'(WIDTH); s++) b = b ^ (g >> s);
        return b;
    endfunction

    // Advance the reference model with the current inputs, then cross one edge.
    task automatic tick();
        if (rst) begin
            m_cnt = 0; m_dout = 0; m_ov = 0; m_wrap = 0;
        end else begin
            m_ov = 0; m_wrap = 0;
            case (mode)
                2'd0: if (in_valid) begin m_dout = gray_of(int'(din)); m_ov = 1; end
                2'd1: if (in_valid) begin m_dout = bin_of(int'(din)); m_ov = 1; end
                2'd2: begin
                    if (cnt_load) begin
                        m_cnt = int'(din); m_dout = gray_of(m_cnt); m_ov = 1;
                    end else if (cnt_en) begin
                        if (DownEn && cnt_dn) begin
                            m_wrap = (m_cnt == 0) ? 1 : 0;
                            m_cnt  = (m_cnt + MOD - 1) % MOD;
                        end else begin
                            m_wrap = (m_cnt == MOD - 1) ? 1 : 0;
                            m_cnt  = (m_cnt + 1) % MOD;
                        end
                        m_dout = gray_of(m_cnt); m_ov = 1;
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; mode = 2'd3; in_valid = 0; din = '0;
        cnt_en = 0; cnt_load = 0; cnt_dn = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; mode = 2'd2; cnt_en = 1; cnt_load = 1; din = 3'd5; in_valid = 1;
        tick();
        checks++; if (dout !== 3'd0) begin failures++; $display("FAIL reset_dout got=%0d exp=0", dout); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_ov got=%0b exp=0", out_valid); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%0b exp=0", wrap); end
        idle_inputs();
    endtask

    task automatic test_bin2gray();
        idle_inputs();
        mode = 2'd0; in_valid = 1; din = 3'd5;
        tick();
        checks++; if (dout !== 3'd7) begin failures++; $display("FAIL b2g_dout got=%0d exp=7", dout); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2g_ov got=%0b exp=1", out_valid); end
        in_valid = 0; din = 3'd2;
        tick();
        checks++; if (dout !== 3'd7) begin failures++; $display("FAIL b2g_hold_dout got=%0d exp=7", dout); end
        checks++; if (out_valid !== 1'b0 || wrap !== 1'b0) begin
            failures++; $display("FAIL b2g_hold_flags got=%0b%0b exp=00", out_valid, wrap);
        end
    endtask

    task automatic test_gray2bin();
        idle_inputs();
        mode = 2'd1; in_valid = 1; din = 3'd7;
        tick();
        checks++; if (dout !== 3'd5) begin failures++; $display("FAIL g2b_dout got=%0d exp=5", dout); end
        for (int x = 0; x < MOD; x++) begin
            din = WIDTH'(gray_of(x));
            tick();
            checks++; if (dout !== WIDTH'(x) || out_valid !== 1'b1) begin
                failures++; $display("FAIL g2b_sweep x=%0d got=%0d/%0b exp=%0d/1", x, dout, out_valid, x);
            end
        end
    endtask

    task automatic test_count_seq();
        int exp_seq[8] = '{1, 3, 2, 6, 7, 5, 4, 0};
        idle_inputs();
        rst = 1; tick(); rst = 0;
        mode = 2'd2; cnt_en = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (dout !== WIDTH'(exp_seq[i]) || out_valid !== 1'b1) begin
                failures++; $display("FAIL count_seq i=%0d got=%0d/%0b exp=%0d/1", i, dout, out_valid, exp_seq[i]);
            end
            checks++; if (wrap !== (i == 7)) begin
                failures++; $display("FAIL count_wrap i=%0d got=%0b exp=%0b", i, wrap, (i == 7));
            end
        end
    endtask

    task automatic test_load_reset();
        idle_inputs();
        mode = 2'd2; cnt_load = 1; cnt_en = 1; din = 3'd6;
        tick();
        checks++; if (dout !== 3'd5 || wrap !== 1'b0 || out_valid !== 1'b1) begin
            failures++; $display("FAIL load got=%0d/w%0b/v%0b exp=5/w0/v1", dout, wrap, out_valid);
        end
        cnt_load = 0;
        tick();
        checks++; if (dout !== 3'd4) begin failures++; $display("FAIL load_step got=%0d exp=4", dout); end
        rst = 1;
        tick();
        checks++; if (dout !== 3'd0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL mid_reset got=%0d/v%0b exp=0/v0", dout, out_valid);
        end
        rst = 0;
        tick();
        checks++; if (dout !== 3'd1 || wrap !== 1'b0) begin
            failures++; $display("FAIL restart got=%0d/w%0b exp=1/w0", dout, wrap);
        end
    endtask

    task automatic test_hold_preserve();
        idle_inputs();
        mode = 2'd2; cnt_load = 1; din = 3'd2;
        tick();
        cnt_load = 0; mode = 2'd3; cnt_en = 1;
        tick();
        checks++; if (dout !== 3'd3 || out_valid !== 1'b0) begin
            failures++; $display("FAIL hold got=%0d/v%0b exp=3/v0", dout, out_valid);
        end
        mode = 2'd0; in_valid = 1; din = 3'd0;
        tick();
        checks++; if (dout !== 3'd0) begin failures++; $display("FAIL conv_in_count got=%0d exp=0", dout); end
        mode = 2'd2; in_valid = 0;
        tick();
        checks++; if (dout !== 3'd2) begin failures++; $display("FAIL cnt_preserved got=%0d exp=2", dout); end
    endtask

    task automatic test_down();
        idle_inputs();
        rst = 1; tick(); rst = 0;
        mode = 2'd2; cnt_en = 1; cnt_dn = 1;
        tick();
`ifdef GRAY_DOWN_EN
        checks++; if (dout !== 3'd4 || wrap !== 1'b1) begin
            failures++; $display("FAIL down got=%0d/w%0b exp=4/w1", dout, wrap);
        end
`else
        checks++; if (dout !== 3'd1 || wrap !== 1'b0) begin
            failures++; $display("FAIL down_ignored got=%0d/w%0b exp=1/w0", dout, wrap);
        end
`endif
    endtask

    task automatic test_random();
        bit step_adj;
        int prev;
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 39) == 0);
            mode     = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
            in_valid = 1'($urandom);
            din      = WIDTH'($urandom);
            cnt_en   = ($urandom_range(0, 3) != 0);
            cnt_load = ($urandom_range(0, 9) == 0);
            cnt_dn   = 1'($urandom);
            step_adj = !rst && mode == 2'd2 && !cnt_load && cnt_en && m_dout == gray_of(m_cnt);
            prev     = m_dout;
            tick();
            checks++; if (dout !== WIDTH'(m_dout) || out_valid !== 1'(m_ov) || wrap !== 1'(m_wrap)) begin
                failures++;
                $display("FAIL random n=%0d got=%0d/v%0b/w%0b exp=%0d/v%0d/w%0d",
                         n, dout, out_valid, wrap, m_dout, m_ov, m_wrap);
            end
            if (step_adj) begin
                checks++; if ($countones(dout ^ WIDTH'(prev)) != 1) begin
                    failures++; $display("FAIL one_bit n=%0d got=%0d prev=%0d", n, dout, prev);
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_bin2gray();
        test_gray2bin();
        test_count_seq();
        test_load_reset();
        test_hold_preserve();
        test_down();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_code_unit.md
GRAY_CODE_UNIT -- requirements
Module: gray_code_unit

Interface
REQ-001 Parameter WIDTH, default 3, code width in bits (legal range 2..16).
REQ-002 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  reset; synchronous and active-high.
REQ-004 Port mode  input  2  operating mode: 00 bin2gray, 01 gray2bin, 10 count, 11 hold.
REQ-005 Port in_valid  input  1  din qualifier for conversion modes.
REQ-006 Port din  input  WIDTH  conversion operand, or binary load value in count mode.
REQ-007 Port cnt_en  input  1  count-step enable in count mode.
REQ-008 Port cnt_load  input  1  load counter from din in count mode.
REQ-009 Port cnt_dn  input  1  count direction, 1 = down; ignored unless GRAY_DOWN_EN is defined.
REQ-010 Port dout  output  WIDTH  registered result.
REQ-011 Port out_valid  output  1  registered; high for one cycle per new dout.
REQ-012 Port wrap  output  1  registered one-cycle pulse on counter wrap-around.

Function
REQ-013 bin2gray: when in_valid=1, dout SHALL equal din ^ (din >> 1) on the next edge, with out_valid=1 (latency 1).
REQ-014 gray2bin: when in_valid=1, dout SHALL satisfy dout[WIDTH-1]=din[WIDTH-1] and dout[i]=dout[i+1]^din[i] for all lower bits, on the next edge, with out_valid=1.
REQ-015 Conversion mode with in_valid=0: dout SHALL hold its value, out_valid=0, wrap=0.
REQ-016 The internal binary counter cnt (WIDTH bits) SHALL change only in count mode; conversion and hold modes preserve it.
REQ-017 Count mode priority: cnt_load over cnt_en; load sets cnt=din, with dout=gray(din) and out_valid=1 on the next edge.
REQ-018 Count mode, cnt_en=1, no load: cnt SHALL step by one modulo 2^WIDTH, with dout=gray(new cnt) and out_valid=1 on the same edge.
REQ-019 Count mode, cnt_en=0 and cnt_load=0: cnt and dout SHALL hold, out_valid=0.
REQ-020 wrap SHALL be 1 for exactly the cycle after a step from 2^WIDTH-1 to 0 (up) or from 0 to 2^WIDTH-1 (down); a load never asserts wrap.
REQ-021 Consecutive count-mode dout values SHALL differ in exactly one bit, except across a load.
REQ-022 Hold mode (11): dout and cnt SHALL hold, out_valid=0, wrap=0.
REQ-023 A mode change takes effect on the edge where the new mode is sampled; there is no pipeline flush and no extra latency.

Reset
REQ-024 rst=1 at an edge SHALL force cnt=0, dout=0, out_valid=0, wrap=0, overriding every other input.
REQ-025 Reset asserted mid-count SHALL discard any pending step or load; counting restarts from 0 on the first enabled edge after release.

Configuration
REQ-026 Macro GRAY_DOWN_EN defined: cnt_dn=1 with cnt_en=1 in count mode SHALL decrement cnt modulo 2^WIDTH, with wrap per REQ-020.
REQ-027 Macro GRAY_DOWN_EN undefined: cnt_dn SHALL be ignored, the counter counts up only, and the down-count logic SHALL not be synthesised.

Verification (WIDTH=3)
REQ-028 mode=00, in_valid=1, din=5 -> dout=7, out_valid=1 one cycle later; then in_valid=0 -> out_valid=0, dout stays 7.
REQ-029 mode=01, in_valid=1, din=7 -> dout=5 next cycle; sweep of all 8 gray2bin(bin2gray(x)) results returns x.
REQ-030 After reset, mode=10, cnt_en=1 for 8 cycles -> dout sequence 1,3,2,6,7,5,4,0; wrap=1 only with the final 0.
REQ-031 mode=10, cnt_load=1, cnt_en=1, din=6 -> dout=5, wrap=0, no increment; then rst=1 during counting -> dout=0, out_valid=0 next edge.
REQ-032 GRAY_DOWN_EN defined, cnt=0, cnt_dn=1, cnt_en=1 -> dout=4, wrap=1; undefined build with the same stimulus -> dout=1, wrap=0.
